sensor_poll_ctrl: RTL
=====================

Name: sensor_poll_ctrl

Overview:
- Round-robin polling controller for a bank of NUM_CH 4-bit sensor words that share one multiplexed input bus.
- Drives the channel select and samples each channel once per scan.
- Applies the sensor error rule, debounces it per channel and raises a sticky alarm, which is cleared by an acknowledge handshake.
- Sits between the sensor mux and the system status/interrupt logic.

Parameters:
NUM_CH, 4, number of polled sensor channels (2..16)
POLL_PERIOD, 16, idle cycles between the end of one scan and the start of the next (>=1)
DEBOUNCE, 3, consecutive erroneous samples required to flag a channel (1..15)

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
enable  input  1  level; high allows scans to start
sensors_in  input  4  sensor word of the currently selected channel; valid one cycle after ch_sel changes
ack  input  1  single-cycle pulse; clears all flags and debounce counters
ch_sel  output  $clog2(NUM_CH)  channel select to the external mux
err_flags  output  NUM_CH  sticky per-channel error flags
alarm  output  1  OR of err_flags
alarm_ch  output  $clog2(NUM_CH)  lowest-index set flag; 0 when no flag is set
scan_done  output  1  one-cycle pulse at the end of each scan

Behaviour:
- Clock and reset: one clock, clk. Reset n_rst is asynchronous and active-low.
- Reset values: state=IDLE, ch_sel=0, err_flags=0, alarm=0, alarm_ch=0, scan_done=0, all debounce counters=0, period counter=0.
- Error rule (combinational on sensors_in): err = s[0] | (s[1] & (s[2] | s[3])).
- FSM states: IDLE, SETTLE, SAMPLE, DONE, WAIT.
  - IDLE: ch_sel=0. Goes to SETTLE on the first cycle enable=1.
  - SETTLE: one cycle. ch_sel holds the current channel so the mux output can settle. Goes to SAMPLE.
  - SAMPLE: evaluates err on sensors_in and updates that channel's counter and flag. If ch_sel==NUM_CH-1, goes to DONE; otherwise ch_sel+1 and goes to SETTLE.
  - DONE: scan_done=1 for exactly this cycle. ch_sel=0. Loads the period counter with POLL_PERIOD. Goes to WAIT.
  - WAIT: decrements the period counter. When it reaches 0: goes to SETTLE if enable=1, else IDLE. WAIT lasts exactly POLL_PERIOD cycles.
- Scan timing: a scan is 2*NUM_CH+1 cycles (DONE included). Scan-start to scan-start is 2*NUM_CH+1+POLL_PERIOD cycles; with defaults, 25.
- Enable:
  - Dropping enable mid-scan does not abort the scan. The scan completes, including DONE and WAIT, and the FSM then enters IDLE.
  - Dropping enable in WAIT takes effect at WAIT expiry.
  - Flags are retained while idle.
- Debounce counter per channel, width $clog2(DEBOUNCE+1), saturating at DEBOUNCE:
  - Sample with err=1: cnt = min(cnt+1, DEBOUNCE).
  - Sample with err=0: cnt=0.
  - The flag sets on the sample where the new cnt equals DEBOUNCE. Further erroneous samples keep it set.
  - A clean sample does not clear a set flag (flags are sticky).
- Ack:
  - Clears every err_flags bit and every counter on the following edge.
  - If ack coincides with a SAMPLE that would set channel k's flag, set wins for channel k: flag k=1 and cnt k=DEBOUNCE. All other channels clear.
  - ack is legal in any state and does not disturb FSM sequencing.
- alarm and alarm_ch are decoded combinationally from the err_flags register only, so they are glitch-free relative to sensors_in. They update in the same cycle err_flags changes.
- Asynchronous reset mid-scan: everything returns to reset values immediately. The first post-reset scan starts at channel 0.
- No other input combination is illegal. sensors_in is ignored outside SAMPLE.

Decomposition:
- Shared package sensor_pkg holds:
  - state enum poll_state_t {IDLE, SETTLE, SAMPLE, DONE, WAIT};
  - the 4-bit sensor word typedef sensor_word_t;
  - localparam SENSOR_W=4.
- One sub-module, sensor_err_eval: combinational, input sensor_word_t, output err. It is shared with any other block needing the same rule.
- Debounce counters are a generate-indexed register array inside sensor_poll_ctrl.

Test Plan (NUM_CH=4, POLL_PERIOD=16, DEBOUNCE=3):
1. Reset, enable=1, sensors_in=4'b0000 always -> ch_sel sequence 0,0,1,1,2,2,3,3 then 0; scan_done pulses every 25 cycles; err_flags stays 0, alarm=0.
2. Channel 2 returns 4'b0110, others 0 -> err_flags=4'b0100 after the SAMPLE of ch2 in the 3rd scan, not earlier; alarm=1, alarm_ch=2.
3. Channel 1 alternates 4'b0001 / 4'b0000 on successive scans -> counter never reaches 3; err_flags stays 0.
4. Channels 3 and 1 both return 4'b1010 -> err_flags=4'b1010, alarm_ch=1. Ack pulse -> err_flags=0, alarm=0 next cycle. Flags re-set after 3 more scans.
5. Ack asserted in the same cycle as ch0's 3rd erroneous SAMPLE while ch2 is already flagged -> err_flags=4'b0001.
6. enable dropped during SETTLE of ch1 -> scan finishes through ch3, scan_done pulses, 16 WAIT cycles, then IDLE. n_rst pulsed mid-scan -> all outputs 0 immediately.

Source files
------------

// File: rtl/sensor_pkg.sv
// ---------------------------------------------------------------------------
// sensor_pkg
// Shared types for the sensor polling blocks:
//   SENSOR_W       width of one sensor word
//   sensor_word_t  one sensor word as seen on the multiplexed bus
//   poll_state_t   polling sequencer states
// ---------------------------------------------------------------------------
package sensor_pkg;

    localparam int SENSOR_W = 4;

    typedef logic [SENSOR_W-1:0] sensor_word_t;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE,
        WAIT
    } poll_state_t;

endpackage

// File: rtl/sensor_err_eval.sv
// ---------------------------------------------------------------------------
// sensor_err_eval
// Combinational sensor error rule, shared by every block that judges a word.
//   word_i  sensor word under evaluation
//   err_o   1 when the word reports an error
// ---------------------------------------------------------------------------
module sensor_err_eval
    import sensor_pkg::*;
(
    input  sensor_word_t word_i,
    output logic         err_o
);

    // Bit 0 is a hard fault; bit 1 is only a fault when qualified by bit 2 or 3.
    assign err_o = word_i[0] | (word_i[1] & (word_i[2] | word_i[3]));

endmodule

// File: rtl/sensor_poll_ctrl.sv
// ---------------------------------------------------------------------------
// sensor_poll_ctrl
// Round-robin poller for NUM_CH sensors sharing one multiplexed bus. Each
// scan settles and samples every channel once, debounces the error rule per
// channel into sticky flags, then idles POLL_PERIOD cycles before the next.
//   clk         system clock, rising edge
//   n_rst       asynchronous active-low reset
//   enable      level; allows a new scan to start
//   sensors_in  sensor word of the selected channel
//   ack         one-cycle pulse; clears all flags and debounce counters
//   ch_sel      channel select to the external mux
//   err_flags   sticky per-channel error flags
//   alarm       OR of err_flags
//   alarm_ch    lowest-index set flag, 0 when none set
//   scan_done   one-cycle pulse at the end of each scan
// ---------------------------------------------------------------------------
module sensor_poll_ctrl
    import sensor_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int POLL_PERIOD = 16,
    parameter int DEBOUNCE    = 3
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      enable,
    input  logic [SENSOR_W-1:0]       sensors_in,
    input  logic                      ack,
    output logic [$clog2(NUM_CH)-1:0] ch_sel,
    output logic [NUM_CH-1:0]         err_flags,
    output logic                      alarm,
    output logic [$clog2(NUM_CH)-1:0] alarm_ch,
    output logic                      scan_done
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam int PER_W = $clog2(POLL_PERIOD + 1);

    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);

    poll_state_t       state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [PER_W-1:0]  per_q, per_d;
    logic [NUM_CH-1:0] flags;
    logic              err;
    logic              sample_en;

    sensor_err_eval u_err_eval (
        .word_i (sensors_in),
        .err_o  (err)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of block order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            per_q   <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            per_q   <= per_d;
        end
    end

    // NOTE: every signal gets its default before the case so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        per_d     = per_q;
        sample_en = 1'b0;
        case (state_q)
            IDLE: begin
                ch_d = '0;
                if (enable) state_d = SETTLE;
            end
            SETTLE: state_d = SAMPLE;
            SAMPLE: begin
                sample_en = 1'b1;
                if (ch_q == LAST_CH) begin
                    // Select returns to channel 0 already during DONE.
                    ch_d    = '0;
                    state_d = DONE;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = SETTLE;
                end
            end
            DONE: begin
                per_d   = PER_W'(POLL_PERIOD);
                state_d = WAIT;
            end
            WAIT: begin
                // Leaving on the count-of-1 cycle makes WAIT last exactly
                // POLL_PERIOD cycles and leaves the counter at 0.
                per_d = per_q - PER_W'(1);
                if (per_q == PER_W'(1)) state_d = enable ? SETTLE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-channel debounce counter and sticky flag.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             flag_q;
        logic             hit;
        logic             set_flag;

        always_comb begin
            hit      = sample_en && (ch_q == CH_W'(g));
            cnt_d    = cnt_q;
            set_flag = 1'b0;
            if (hit) begin
                if (!err)                 cnt_d = '0;
                else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                set_flag = err && (cnt_d == CNT_MAX);
            end
        end

        // A flag being set on this edge takes priority over a simultaneous ack.
        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                cnt_q  <= '0;
                flag_q <= 1'b0;
            end else if (set_flag) begin
                cnt_q  <= cnt_d;
                flag_q <= 1'b1;
            end else if (ack) begin
                cnt_q  <= '0;
                flag_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
            end
        end

        assign flags[g] = flag_q;
    end

    // Alarm outputs decode only registered flags, so they never follow the bus.
    always_comb begin
        alarm_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (flags[i]) alarm_ch = CH_W'(i);
        end
    end

    assign ch_sel    = ch_q;
    assign err_flags = flags;
    assign alarm     = |flags;
    assign scan_done = (state_q == DONE);

endmodule
